// File: rtl/render_frame_scheduler.sv
// render_frame_scheduler: issues raster coordinates to the renderer per start pulse,
// bounds in-flight pixels and turns returned pixels into framebuffer writes.
module render_frame_scheduler #(
    parameter int         START_X       = 390,
    parameter int         END_X         = 634,
    parameter int         START_Y       = 390,
    parameter int         END_Y         = 765,
    parameter int         REGION_DIVIDE = 530,
    parameter logic [1:0] SEL_TOP       = 2'b11,
    parameter logic [1:0] SEL_BOTTOM    = 2'b10,
    parameter int         MAX_INFLIGHT  = 512
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start_in,
    output logic [10:0] hcount_axis_tdata,
    output logic [9:0]  vcount_axis_tdata,
    output logic        coord_axis_tvalid,
    input  logic        coord_axis_tready,
    output logic [1:0]  select_objs,
    input  logic [23:0] pixel_axis_tdata,
    input  logic        pixel_axis_tvalid,
    output logic        fb_we,
    output logic [16:0] fb_addr,
    output logic [11:0] fb_din,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic [15:0] frame_count_out,
    output logic        err_out
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [10:0]   X0   = 11'(START_X);
    localparam logic [10:0]   XL   = 11'(END_X - 1);
    localparam logic [9:0]    Y0   = 10'(START_Y);
    localparam logic [9:0]    YL   = 10'(END_Y - 1);
    localparam logic [9:0]    YD   = 10'(REGION_DIVIDE);
    localparam logic [IW-1:0] MAXI = IW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [10:0]   h;
    logic [9:0]    v;
    logic [IW-1:0] inflight;
    logic [16:0]   idx;
    logic          hs;
    logic          pix_ok;
    logic          last;
    logic          unused_bits;

    assign coord_axis_tvalid = (state == ISSUE) && (inflight < MAXI);
    assign hs                = coord_axis_tvalid && coord_axis_tready;
    assign pix_ok            = pixel_axis_tvalid && (inflight != '0);
    assign last              = (h == XL) && (v == YL);
    assign hcount_axis_tdata = h;
    assign vcount_axis_tdata = v;
    assign select_objs       = (v < YD) ? SEL_TOP : SEL_BOTTOM;
    assign busy_out          = (state != IDLE);
    assign frame_done_out    = (state == DONE);
    assign unused_bits       = ^{pixel_axis_tdata[19:16],
                                 pixel_axis_tdata[11:8],
                                 pixel_axis_tdata[3:0]};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start_in) state_nx = ISSUE;
            ISSUE: if (hs && last) state_nx = DRAIN;
            DRAIN: if (inflight == '0) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= IDLE;
            h               <= X0;
            v               <= Y0;
            inflight        <= '0;
            idx             <= '0;
            fb_we           <= 1'b0;
            fb_addr         <= '0;
            fb_din          <= '0;
            frame_count_out <= '0;
            err_out         <= 1'b0;
        end else begin
            state <= state_nx;
            fb_we <= pix_ok;
            if (pix_ok) begin
                fb_addr <= idx;
                fb_din  <= {pixel_axis_tdata[23:20],
                            pixel_axis_tdata[15:12],
                            pixel_axis_tdata[7:4]};
                idx     <= idx + 17'd1;
            end
            // A pixel with nothing outstanding is a protocol error, never a write
            if (pixel_axis_tvalid && inflight == '0)
                err_out <= 1'b1;
            if (hs && !pix_ok)
                inflight <= inflight + IW'(1);
            else if (!hs && pix_ok)
                inflight <= inflight - IW'(1);
            if (state == IDLE && start_in) begin
                h       <= X0;
                v       <= Y0;
                idx     <= '0;
                fb_addr <= '0;
            end else if (hs) begin
                if (h == XL) begin
                    h <= X0;
                    v <= v + 10'd1;
                end else begin
                    h <= h + 11'd1;
                end
            end
            if (state == DONE)
                frame_count_out <= frame_count_out + 16'd1;
        end
    end
endmodule

// File: tb/tb_render_frame_scheduler.sv
// Directed bench for render_frame_scheduler on a 4x3 window with a
// fixed-latency renderer model; a second instance exercises MAX_INFLIGHT=2.
module tb_render_frame_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_start, a_tv, a_tr, a_pv, a_we, a_busy, a_done, a_err;
    logic [10:0] a_h;
    logic [9:0]  a_v;
    logic [1:0]  a_sel;
    logic [23:0] a_pd;
    logic [16:0] a_addr;
    logic [11:0] a_din;
    logic [15:0] a_fc;

    logic        b_start, b_tv, b_tr, b_pv, b_we, b_busy, b_done, b_err;
    logic [10:0] b_h;
    logic [9:0]  b_v;
    logic [1:0]  b_sel;
    logic [23:0] b_pd;
    logic [16:0] b_addr;
    logic [11:0] b_din;
    logic [15:0] b_fc;

    render_frame_scheduler #(
        .START_X(0), .END_X(4), .START_Y(0), .END_Y(3),
        .REGION_DIVIDE(1), .MAX_INFLIGHT(16)
    ) dut_a (
        .aclk(clk), .aresetn(rst_n), .start_in(a_start),
        .hcount_axis_tdata(a_h), .vcount_axis_tdata(a_v),
        .coord_axis_tvalid(a_tv), .coord_axis_tready(a_tr),
        .select_objs(a_sel), .pixel_axis_tdata(a_pd),
        .pixel_axis_tvalid(a_pv), .fb_we(a_we), .fb_addr(a_addr),
        .fb_din(a_din), .busy_out(a_busy), .frame_done_out(a_done),
        .frame_count_out(a_fc), .err_out(a_err)
    );

    render_frame_scheduler #(
        .START_X(0), .END_X(4), .START_Y(0), .END_Y(3),
        .REGION_DIVIDE(1), .MAX_INFLIGHT(2)
    ) dut_b (
        .aclk(clk), .aresetn(rst_n), .start_in(b_start),
        .hcount_axis_tdata(b_h), .vcount_axis_tdata(b_v),
        .coord_axis_tvalid(b_tv), .coord_axis_tready(b_tr),
        .select_objs(b_sel), .pixel_axis_tdata(b_pd),
        .pixel_axis_tvalid(b_pv), .fb_we(b_we), .fb_addr(b_addr),
        .fb_din(b_din), .busy_out(b_busy), .frame_done_out(b_done),
        .frame_count_out(b_fc), .err_out(b_err)
    );

    // Renderer models: fixed latency 5 (A) and 10 (B); not reset, so they
    // keep returning pixels across a DUT reset.
    logic [15:0] a_pipe = '0;
    logic [15:0] b_pipe = '0;
    initial forever begin
        @(posedge clk);
        a_pipe <= {a_pipe[14:0], a_tv & a_tr};
        b_pipe <= {b_pipe[14:0], b_tv & b_tr};
    end
    assign a_pv = a_pipe[4];
    assign b_pv = b_pipe[9];

    logic [22:0] a_cq[$];
    int          a_cc[$];
    logic [16:0] a_aq[$];
    logic [11:0] a_dq[$];
    int   cyc = 0;
    int   a_outst = 0, a_ndone = 0, a_nwe = 0;
    int   a_stall_bad = 0, a_we_bad = 0;
    logic a_okp = 1'b0, a_pend = 1'b0;
    logic [22:0] a_last = '0, a_cur;

    initial forever begin
        @(negedge clk);
        cyc++;
        a_cur = {a_sel, a_v, a_h};
        if (a_we !== (a_okp && rst_n)) a_we_bad++;
        if (a_pend && !(a_tv === 1'b1 && a_cur === a_last)) a_stall_bad++;
        a_pend = a_tv && !a_tr;
        a_last = a_cur;
        if (a_tv && a_tr) begin
            a_cq.push_back(a_cur);
            a_cc.push_back(cyc);
        end
        if (a_we) begin
            a_aq.push_back(a_addr);
            a_dq.push_back(a_din);
            a_nwe++;
        end
        if (a_done) a_ndone++;
        a_okp = rst_n && a_pv && (a_outst > 0);
        if (!rst_n) a_outst = 0;
        else a_outst += int'(a_tv && a_tr) - int'(a_okp);
    end

    int b_outst = 0, b_bad = 0, b_full = 0;
    int b_ncoord = 0, b_nwe = 0, b_ndone = 0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            b_outst = 0;
        end else begin
            if (b_tv && b_outst >= 2) b_bad++;
            if (b_outst > 2) b_bad++;
            if (b_outst == 2) b_full++;
            if (b_tv && b_tr) b_ncoord++;
            if (b_we) begin
                if (b_addr != 17'(b_nwe)) b_bad++;
                b_nwe++;
            end
            if (b_done) b_ndone++;
            b_outst += int'(b_tv && b_tr) - int'(b_pv && b_outst > 0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_a;
        a_cq.delete();
        a_cc.delete();
        a_aq.delete();
        a_dq.delete();
        a_ndone = 0;
        a_nwe = 0;
    endtask

    task automatic run_a(input bit rnd, input bit spam, output bit ok);
        ok = 1'b0;
        a_tr = 1'b1;
        a_start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick;
            a_tr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            a_start = spam && a_busy;
            if (a_done) begin
                ok = 1'b1;
                tick;
                a_start = 1'b0;
                break;
            end
        end
        a_start = 1'b0;
        a_tr = 1'b1;
    endtask

    task automatic chk_pass(input string tag, input logic [11:0] din_e);
        logic [22:0] e;
        chk({tag, "_ncoord"}, a_cq.size(), 12);
        chk({tag, "_nwrite"}, a_aq.size(), 12);
        for (int i = 0; i < 12; i++) begin
            e = {(i < 4) ? 2'b11 : 2'b10, 10'(i / 4), 11'(i % 4)};
            if (i < a_cq.size()) chk({tag, "_coord"}, a_cq[i], e);
            if (i < a_aq.size()) chk({tag, "_addr"}, a_aq[i], i);
            if (i < a_dq.size()) chk({tag, "_din"}, a_dq[i], din_e);
        end
        chk({tag, "_ndone"}, a_ndone, 1);
        chk({tag, "_err"}, a_err, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_stall"}, a_stall_bad, 0);
        chk({tag, "_we_timing"}, a_we_bad, 0);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        a_tr = 1'b1;
        b_tr = 1'b1;
        a_pd = 24'h123456;
        b_pd = 24'h0F0F0F;
        tick;
        tick;
        chk("rst_tvalid", a_tv, 0);
        chk("rst_we", a_we, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_din", a_din, 0);
        chk("rst_fc", a_fc, 0);
        chk("rst_h", a_h, 0);
        chk("rst_v", a_v, 0);
        chk("rst_sel", a_sel, 2'b11);
        rst_n = 1'b1;
        tick;
        tick;
        chk("idle_tvalid", a_tv, 0);

        // full speed pass
        clr_a;
        run_a(1'b0, 1'b0, ok);
        chk("t1_ok", ok, 1);
        chk_pass("t1", 12'h135);
        if (a_cc.size() == 12) chk("t1_span", a_cc[11] - a_cc[0], 11);
        chk("t1_fc", a_fc, 1);

        // random back-pressure
        clr_a;
        run_a(1'b1, 1'b0, ok);
        chk("t2_ok", ok, 1);
        chk_pass("t2", 12'h135);
        chk("t2_fc", a_fc, 2);

        // in-flight bound of 2 with latency 10
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick;
            if (b_done) begin
                ok = 1'b1;
                break;
            end
        end
        tick;
        chk("t3_ok", ok, 1);
        chk("t3_bad", b_bad, 0);
        chk("t3_full_seen", b_full > 0, 1);
        chk("t3_ncoord", b_ncoord, 12);
        chk("t3_nwe", b_nwe, 12);
        chk("t3_ndone", b_ndone, 1);
        chk("t3_fc", b_fc, 1);
        chk("t3_err", b_err, 0);

        // start pulses in ISSUE, DRAIN and DONE are ignored
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        clr_a;
        run_a(1'b0, 1'b1, ok);
        tick;
        tick;
        chk("t4_ok", ok, 1);
        chk("t4_ndone", a_ndone, 1);
        chk("t4_fc", a_fc, 1);
        chk("t4_busy", a_busy, 0);
        chk("t4_ncoord", a_cq.size(), 12);

        // second pass with nibble-extraction pattern
        clr_a;
        a_pd = 24'hABCDEF;
        run_a(1'b0, 1'b0, ok);
        chk("t5_ok", ok, 1);
        chk_pass("t5", 12'hACE);
        chk("t5_fc", a_fc, 2);

        // reset mid-ISSUE, renderer still returns 3 pixels
        clr_a;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        chk("t6_issue_tvalid", a_tv, 1);
        tick;
        tick;
        tick;
        chk("t6_nhs", a_cq.size(), 3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", a_busy, 0);
        chk("t6_rst_tvalid", a_tv, 0);
        chk("t6_rst_fc", a_fc, 0);
        chk("t6_rst_h", a_h, 0);
        tick;
        rst_n = 1'b1;
        repeat (5) tick;
        chk("t6_err", a_err, 1);
        chk("t6_nwe", a_nwe, 0);
        chk("t6_busy", a_busy, 0);
        chk("t6_tvalid", a_tv, 0);
        chk("t6_fc", a_fc, 0);
        chk("t6_addr", a_addr, 0);
        chk("t6_h", a_h, 0);
        chk("t6_v", a_v, 0);
        chk("t6_we_timing", a_we_bad, 0);
        tick;
        chk("t6_err_sticky", a_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
